// File: rtl/reservation_station.sv
// rtl/reservation_station.sv - ALU reservation station with CDB wakeup and lowest-index select
// Holds issued instructions until both operands are captured, then dispatches one per cycle.
module reservation_station #(
  parameter int XLEN     = 32,
  parameter int RS_SIZE  = 8,
  parameter int RS_IDX_W = 3,
  parameter int ROB_ID_W = 3,
  parameter int ALU_OP_W = 4
) (
  input  logic                clk_in,
  input  logic                rst_n,
  input  logic                rdy_in,
  input  logic                flush_in,
  input  logic                issue_valid,
  input  logic [ALU_OP_W-1:0] issue_op,
  input  logic [ROB_ID_W-1:0] issue_rob_id,
  input  logic                issue_q1_rdy,
  input  logic [XLEN-1:0]     issue_v1,
  input  logic [ROB_ID_W-1:0] issue_q1,
  input  logic                issue_q2_rdy,
  input  logic [XLEN-1:0]     issue_v2,
  input  logic [ROB_ID_W-1:0] issue_q2,
  input  logic                cdb_valid,
  input  logic [ROB_ID_W-1:0] cdb_rob_id,
  input  logic [XLEN-1:0]     cdb_val,
  output logic                rs_full,
  output logic                alu_valid,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic [XLEN-1:0]     alu_v1,
  output logic [XLEN-1:0]     alu_v2,
  output logic [ROB_ID_W-1:0] rs_remove_id
);

  logic [RS_SIZE-1:0]  busy;
  logic [RS_SIZE-1:0]  q1_rdy;
  logic [RS_SIZE-1:0]  q2_rdy;
  logic [ALU_OP_W-1:0] e_op  [RS_SIZE];
  logic [ROB_ID_W-1:0] e_rob [RS_SIZE];
  logic [ROB_ID_W-1:0] e_q1  [RS_SIZE];
  logic [ROB_ID_W-1:0] e_q2  [RS_SIZE];
  logic [XLEN-1:0]     e_v1  [RS_SIZE];
  logic [XLEN-1:0]     e_v2  [RS_SIZE];

  logic [RS_IDX_W-1:0] free_idx;
  logic [RS_IDX_W-1:0] sel_idx;
  logic                sel_found;
  logic                issue_fire;
  logic                bypass1;
  logic                bypass2;

  assign rs_full    = &busy;
  assign issue_fire = issue_valid && !rs_full;
  assign bypass1    = cdb_valid && (cdb_rob_id == issue_q1);
  assign bypass2    = cdb_valid && (cdb_rob_id == issue_q2);

  // Descending scan so the lowest matching index is the one left standing.
  always_comb begin
    free_idx  = '0;
    sel_idx   = '0;
    sel_found = 1'b0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (!busy[i]) free_idx = RS_IDX_W'(i);
      if (busy[i] && q1_rdy[i] && q2_rdy[i]) begin
        sel_found = 1'b1;
        sel_idx   = RS_IDX_W'(i);
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      busy         <= '0;
      alu_valid    <= 1'b0;
      alu_op       <= '0;
      alu_v1       <= '0;
      alu_v2       <= '0;
      rs_remove_id <= '0;
    end else if (!rdy_in) begin
      alu_valid <= 1'b0;
    end else if (flush_in) begin
      busy      <= '0;
      alu_valid <= 1'b0;
    end else begin
      alu_valid <= sel_found;
      if (sel_found) begin
        alu_op        <= e_op[sel_idx];
        alu_v1        <= e_v1[sel_idx];
        alu_v2        <= e_v2[sel_idx];
        rs_remove_id  <= e_rob[sel_idx];
        busy[sel_idx] <= 1'b0;
      end
      for (int i = 0; i < RS_SIZE; i++) begin
        if (busy[i] && cdb_valid) begin
          if (!q1_rdy[i] && e_q1[i] == cdb_rob_id) begin
            e_v1[i]   <= cdb_val;
            q1_rdy[i] <= 1'b1;
          end
          if (!q2_rdy[i] && e_q2[i] == cdb_rob_id) begin
            e_v2[i]   <= cdb_val;
            q2_rdy[i] <= 1'b1;
          end
        end
      end
      // The free slot comes from registered state, so it never aliases this cycle's dispatch.
      if (issue_fire) begin
        busy[free_idx]   <= 1'b1;
        e_op[free_idx]   <= issue_op;
        e_rob[free_idx]  <= issue_rob_id;
        e_q1[free_idx]   <= issue_q1;
        e_q2[free_idx]   <= issue_q2;
        q1_rdy[free_idx] <= issue_q1_rdy || bypass1;
        q2_rdy[free_idx] <= issue_q2_rdy || bypass2;
        e_v1[free_idx]   <= issue_q1_rdy ? issue_v1 : cdb_val;
        e_v2[free_idx]   <= issue_q2_rdy ? issue_v2 : cdb_val;
      end
    end
  end

endmodule

// File: tb/tb_reservation_station.sv
// tb/tb_reservation_station.sv - scoreboard bench for reservation_station
// Driver predicts each edge's outcome into a queue; a monitor pops and compares after every edge.
module tb_reservation_station;

  logic        clk = 1'b0;
  logic        rst_n, rdy_in, flush_in;
  logic        issue_valid, issue_q1_rdy, issue_q2_rdy, cdb_valid;
  logic [3:0]  issue_op;
  logic [2:0]  issue_rob_id, issue_q1, issue_q2, cdb_rob_id;
  logic [31:0] issue_v1, issue_v2, cdb_val;
  logic        rs_full, alu_valid;
  logic [3:0]  alu_op;
  logic [31:0] alu_v1, alu_v2;
  logic [2:0]  rs_remove_id;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reservation_station dut (
    .clk_in(clk), .rst_n(rst_n), .rdy_in(rdy_in), .flush_in(flush_in),
    .issue_valid(issue_valid), .issue_op(issue_op), .issue_rob_id(issue_rob_id),
    .issue_q1_rdy(issue_q1_rdy), .issue_v1(issue_v1), .issue_q1(issue_q1),
    .issue_q2_rdy(issue_q2_rdy), .issue_v2(issue_v2), .issue_q2(issue_q2),
    .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id), .cdb_val(cdb_val),
    .rs_full(rs_full), .alu_valid(alu_valid), .alu_op(alu_op),
    .alu_v1(alu_v1), .alu_v2(alu_v2), .rs_remove_id(rs_remove_id)
  );

  typedef struct {
    logic        busy;
    logic [3:0]  op;
    logic [2:0]  rob;
    logic        r1, r2;
    logic [31:0] v1, v2;
    logic [2:0]  q1, q2;
  } slot_t;

  typedef struct {
    logic        valid;
    logic        full;
    logic        chk_fields;
    logic [3:0]  op;
    logic [31:0] v1, v2;
    logic [2:0]  id;
  } exp_t;

  slot_t       m [8];
  logic [3:0]  m_op;
  logic [31:0] m_v1, m_v2;
  logic [2:0]  m_id;
  exp_t        exp_q [$];

  function automatic logic all_busy();
    for (int i = 0; i < 8; i++) if (!m[i].busy) return 1'b0;
    return 1'b1;
  endfunction

  // Reference: applies the station's rules to the inputs presented for the coming edge.
  function automatic void model_step();
    exp_t e;
    int   pick = -1;
    int   free = -1;
    logic was_full;
    e.valid = 1'b0;
    e.chk_fields = 1'b0;
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) m[i].busy = 1'b0;
      m_op = '0; m_v1 = '0; m_v2 = '0; m_id = '0;
      e.chk_fields = 1'b1;
    end else if (rdy_in && flush_in) begin
      for (int i = 0; i < 8; i++) m[i].busy = 1'b0;
    end else if (rdy_in) begin
      was_full = all_busy();
      for (int i = 7; i >= 0; i--) begin
        if (!m[i].busy) free = i;
        if (m[i].busy && m[i].r1 && m[i].r2) pick = i;
      end
      if (pick >= 0) begin
        e.valid = 1'b1;
        e.chk_fields = 1'b1;
        m_op = m[pick].op; m_v1 = m[pick].v1; m_v2 = m[pick].v2; m_id = m[pick].rob;
        m[pick].busy = 1'b0;
      end
      if (cdb_valid) begin
        for (int i = 0; i < 8; i++) begin
          if (m[i].busy && !m[i].r1 && m[i].q1 == cdb_rob_id) begin m[i].r1 = 1'b1; m[i].v1 = cdb_val; end
          if (m[i].busy && !m[i].r2 && m[i].q2 == cdb_rob_id) begin m[i].r2 = 1'b1; m[i].v2 = cdb_val; end
        end
      end
      if (issue_valid && !was_full) begin
        m[free].busy = 1'b1;
        m[free].op = issue_op; m[free].rob = issue_rob_id;
        m[free].q1 = issue_q1; m[free].q2 = issue_q2;
        m[free].r1 = issue_q1_rdy; m[free].v1 = issue_v1;
        m[free].r2 = issue_q2_rdy; m[free].v2 = issue_v2;
        if (!issue_q1_rdy && cdb_valid && cdb_rob_id == issue_q1) begin m[free].r1 = 1'b1; m[free].v1 = cdb_val; end
        if (!issue_q2_rdy && cdb_valid && cdb_rob_id == issue_q2) begin m[free].r2 = 1'b1; m[free].v2 = cdb_val; end
      end
    end
    e.full = all_busy();
    e.op = m_op; e.v1 = m_v1; e.v2 = m_v2; e.id = m_id;
    exp_q.push_back(e);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic idle_pins();
    rst_n = 1'b1; rdy_in = 1'b1; flush_in = 1'b0;
    issue_valid = 1'b0; issue_op = '0; issue_rob_id = '0;
    issue_q1_rdy = 1'b0; issue_v1 = '0; issue_q1 = '0;
    issue_q2_rdy = 1'b0; issue_v2 = '0; issue_q2 = '0;
    cdb_valid = 1'b0; cdb_rob_id = '0; cdb_val = '0;
  endtask

  // Commit the pins for the next edge, then return at the following negedge with idle pins.
  task automatic go();
    model_step();
    @(negedge clk);
    idle_pins();
  endtask

  task automatic iss(input logic [3:0] op, input logic [2:0] rob,
                     input logic r1, input logic [31:0] v1, input logic [2:0] q1,
                     input logic r2, input logic [31:0] v2, input logic [2:0] q2);
    issue_valid = 1'b1; issue_op = op; issue_rob_id = rob;
    issue_q1_rdy = r1; issue_v1 = v1; issue_q1 = q1;
    issue_q2_rdy = r2; issue_v2 = v2; issue_q2 = q2;
  endtask

  task automatic cdb(input logic [2:0] id, input logic [31:0] val);
    cdb_valid = 1'b1; cdb_rob_id = id; cdb_val = val;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("rs_full", 32'(rs_full), 32'(e.full));
        chk("alu_valid", 32'(alu_valid), 32'(e.valid));
        if (e.chk_fields) begin
          chk("alu_op", 32'(alu_op), 32'(e.op));
          chk("alu_v1", alu_v1, e.v1);
          chk("alu_v2", alu_v2, e.v2);
          chk("rs_remove_id", 32'(rs_remove_id), 32'(e.id));
        end
      end
    end
  end

  initial begin : driver
    idle_pins();
    rst_n = 1'b0;
    go();
    go();

    // Reset with three waiting entries
    for (int i = 0; i < 3; i++) begin iss(4'h3, 3'(i), 1'b0, 0, 3'd6, 1'b1, 1, 0); go(); end
    rst_n = 1'b0; go();
    go(); go();
    cdb(3'd6, 32'h55); go();
    go();

    // Ready issue
    iss(4'h1, 3'd2, 1'b1, 32'd5, 0, 1'b1, 32'd7, 0); go();
    go(); go();

    // Wakeup after idle cycles
    iss(4'h2, 3'd4, 1'b0, 0, 3'd1, 1'b1, 32'h9, 0); go();
    go(); go(); go();
    cdb(3'd1, 32'hDEAD); go();
    go(); go();

    // Same-cycle bypass on operand 2
    iss(4'h5, 3'd0, 1'b1, 32'h22, 0, 1'b0, 0, 3'd3); cdb(3'd3, 32'h10); go();
    go(); go();

    // Fill, drop, then ordered drain
    for (int i = 0; i < 8; i++) begin iss(4'(i), 3'(i), 1'b0, 0, 3'd7, 1'b1, 32'(100 + i), 0); go(); end
    iss(4'hF, 3'd5, 1'b1, 32'hBAD, 0, 1'b1, 32'hBAD, 0); go();
    cdb(3'd7, 32'hCAFE); go();
    repeat (10) go();

    // Flush with four ready entries
    for (int i = 0; i < 4; i++) begin iss(4'h6, 3'(i), 1'b0, 0, 3'd5, 1'b0, 0, 3'd5); go(); end
    cdb(3'd5, 32'h77); go();
    flush_in = 1'b1; go();
    repeat (3) go();

    // Stall holds a ready entry
    iss(4'h7, 3'd3, 1'b1, 32'h1234, 0, 1'b1, 32'h5678, 0); rdy_in = 1'b1; go();
    for (int i = 0; i < 3; i++) begin rdy_in = 1'b0; go(); end
    go(); go();

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 99) < 60)
        iss(4'($urandom), 3'($urandom), 1'($urandom), $urandom, 3'($urandom),
            1'($urandom), $urandom, 3'($urandom));
      if ($urandom_range(0, 99) < 50) cdb(3'($urandom), $urandom);
      if ($urandom_range(0, 99) < 10) rdy_in = 1'b0;
      if ($urandom_range(0, 99) < 3) flush_in = 1'b1;
      if ($urandom_range(0, 199) < 1) rst_n = 1'b0;
      go();
    end
    repeat (12) go();

    repeat (2) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
